// File: rtl/ws2812_rx_decoder.sv
// WS2812 single-wire receiver: measures high-pulse widths, rebuilds bytes MSB-first
// and ends a frame on the long-low reset gap, emitting byte/frame pulses.
module ws2812_rx_decoder #(
    parameter  int BIT_THRESH_CYC = 38,
    parameter  int MAX_HIGH_CYC   = 100,
    parameter  int RESET_CYC      = 3200,
    localparam int CNT_W          = $clog2(RESET_CYC + 1)
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        ws2812_data_in,
    output logic        byte_rdy_out,
    output logic [7:0]  byte_data_out,
    output logic        frame_rdy_out,
    output logic [15:0] frame_len_out,
    output logic        err_out
);

    // Handshake: byte_rdy_out/frame_rdy_out/err_out are single-cycle strobes with no
    // backpressure; the data they qualify holds until the next strobe overwrites it.

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        IDLE   = 2'd1,
        HIGH   = 2'd2,
        LOW    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] THRESH   = CNT_W'(BIT_THRESH_CYC);
    localparam logic [CNT_W-1:0] HIGH_LIM = CNT_W'(MAX_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(RESET_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [1:0]       sync_q;
    logic             line_prev;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       shift_q;
    logic [2:0]       bit_cnt;
    logic [15:0]      byte_cnt;

    logic       line;
    logic       rise;
    logic       bit_val;
    logic [7:0] shift_nxt;

    assign line      = sync_q[1];
    assign rise      = line & ~line_prev;
    assign bit_val   = (cnt >= THRESH);
    assign shift_nxt = {shift_q[6:0], bit_val};

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state         <= RESYNC;
            sync_q        <= 2'b00;
            line_prev     <= 1'b0;
            cnt           <= '0;
            shift_q       <= 8'h00;
            bit_cnt       <= 3'd0;
            byte_cnt      <= 16'h0000;
            byte_rdy_out  <= 1'b0;
            byte_data_out <= 8'h00;
            frame_rdy_out <= 1'b0;
            frame_len_out <= 16'h0000;
            err_out       <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], ws2812_data_in};
            line_prev     <= line;
            byte_rdy_out  <= 1'b0;
            frame_rdy_out <= 1'b0;
            err_out       <= 1'b0;

            case (state)
                // Wait for a full reset gap so a stream joined mid-frame is ignored.
                RESYNC: begin
                    if (line) begin
                        cnt <= '0;
                    end else if (cnt >= GAP_LIM) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                IDLE: begin
                    if (rise) begin
                        cnt   <= CNT_ONE;
                        state <= HIGH;
                    end
                end

                HIGH: begin
                    if (line) begin
                        if (cnt >= HIGH_LIM) begin
                            err_out  <= 1'b1;
                            shift_q  <= 8'h00;
                            bit_cnt  <= 3'd0;
                            byte_cnt <= 16'h0000;
                            cnt      <= '0;
                            state    <= RESYNC;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else begin
                        // cnt holds the number of high cycles seen for this bit.
                        shift_q <= shift_nxt;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_data_out <= shift_nxt;
                            byte_rdy_out  <= 1'b1;
                            if (byte_cnt != 16'hFFFF) begin
                                byte_cnt <= byte_cnt + 16'd1;
                            end
                        end
                        cnt   <= '0;
                        state <= LOW;
                    end
                end

                LOW: begin
                    if (line) begin
                        cnt   <= CNT_ONE;
                        state <= HIGH;
                    end else if (cnt >= GAP_LIM) begin
                        frame_rdy_out <= 1'b1;
                        frame_len_out <= byte_cnt;
                        err_out       <= (bit_cnt != 3'd0);
                        shift_q       <= 8'h00;
                        bit_cnt       <= 3'd0;
                        byte_cnt      <= 16'h0000;
                        cnt           <= '0;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: state <= RESYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Directed bench for ws2812_rx_decoder: drives WS2812 waveforms and checks
// decoded bytes, frame lengths and error strobes against hand-computed values.
module tb_ws2812_rx_decoder;

    logic        clk;
    logic        rst_n;
    logic        data;
    logic        byte_rdy;
    logic [7:0]  byte_data;
    logic        frame_rdy;
    logic [15:0] frame_len;
    logic        err;

    ws2812_rx_decoder dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .ws2812_data_in (data),
        .byte_rdy_out   (byte_rdy),
        .byte_data_out  (byte_data),
        .frame_rdy_out  (frame_rdy),
        .frame_len_out  (frame_len),
        .err_out        (err)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // scoreboard state
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          n_frames     = 0;
    int          n_errs       = 0;
    int          n_frame_errs = 0;
    int          n_coincide   = 0;
    logic [15:0] last_len     = 16'h0000;

    always @(negedge clk) begin
        if (byte_rdy) got_q.push_back(byte_data);
        if (frame_rdy) begin
            n_frames++;
            last_len = frame_len;
        end
        if (err) n_errs++;
        if (err && frame_rdy) n_frame_errs++;
        if (byte_rdy && frame_rdy) n_coincide++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            check({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        exp_q.delete();
        got_q.delete();
    endtask

    // driver tasks
    task automatic hold(input logic v, input int n);
        data = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit_t(input int hi, input int lo);
        hold(1'b1, hi);
        hold(1'b0, lo);
    endtask

    task automatic send_bit(input logic b);
        if (b) send_bit_t(51, 29);
        else   send_bit_t(26, 54);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic gap();
        hold(1'b0, 3300);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_byte_rdy"},  32'(byte_rdy),  32'h0);
        check({tag, "_byte_data"}, 32'(byte_data), 32'h0);
        check({tag, "_frame_rdy"}, 32'(frame_rdy), 32'h0);
        check({tag, "_frame_len"}, 32'(frame_len), 32'h0);
        check({tag, "_err"},       32'(err),       32'h0);
    endtask

    int exp_frames = 0;
    int exp_errs   = 0;

    initial begin
        rst_n = 1'b0;
        data  = 1'b0;
        repeat (4) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        gap();

        // single byte A5
        send_byte(8'hA5); exp_q.push_back(8'hA5);
        gap(); exp_frames++;
        check_bytes("a5");
        check("a5_frames", 32'(n_frames), 32'(exp_frames));
        check("a5_len",    32'(last_len), 32'd1);
        check("a5_errs",   32'(n_errs),   32'(exp_errs));

        // 24-bit GRB frame
        send_byte(8'hFF); exp_q.push_back(8'hFF);
        send_byte(8'h00); exp_q.push_back(8'h00);
        send_byte(8'h3C); exp_q.push_back(8'h3C);
        gap(); exp_frames++;
        check_bytes("grb");
        check("grb_frames", 32'(n_frames), 32'(exp_frames));
        check("grb_len",    32'(last_len), 32'd3);

        // threshold: 38 high -> 1, 37 high -> 0
        send_bit_t(38, 42);
        for (int i = 0; i < 7; i++) send_bit_t(37, 43);
        exp_q.push_back(8'h80);
        gap(); exp_frames++;
        check_bytes("thresh");
        check("thresh_len", 32'(last_len), 32'd1);

        // overlong high mid-byte, then recovery
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        hold(1'b1, 100);
        gap(); exp_errs++;
        check_bytes("longhi");
        check("longhi_errs",   32'(n_errs),   32'(exp_errs));
        check("longhi_frames", 32'(n_frames), 32'(exp_frames));
        send_byte(8'h5A); exp_q.push_back(8'h5A);
        gap(); exp_frames++;
        check_bytes("recover");
        check("recover_len",    32'(last_len), 32'd1);
        check("recover_frames", 32'(n_frames), 32'(exp_frames));

        // 12 bits: one byte plus a partial nibble
        send_byte(8'hC3); exp_q.push_back(8'hC3);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        gap(); exp_frames++; exp_errs++;
        check_bytes("partial");
        check("partial_len",       32'(last_len),     32'd1);
        check("partial_errs",      32'(n_errs),       32'(exp_errs));
        check("partial_frame_err", 32'(n_frame_errs), 32'd1);

        // stream joined mid-frame: ignored until the first gap
        pulse_reset();
        send_byte(8'hFF);
        gap();
        check_bytes("midjoin");
        check("midjoin_frames", 32'(n_frames), 32'(exp_frames));
        send_byte(8'h11); exp_q.push_back(8'h11);
        gap(); exp_frames++;
        check_bytes("midjoin_next");
        check("midjoin_len", 32'(last_len), 32'd1);

        // reset after 5 bits drops partial data
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        pulse_reset();
        check_outputs_zero("midreset");
        gap();
        send_byte(8'hE7); exp_q.push_back(8'hE7);
        gap(); exp_frames++;
        check_bytes("after_reset");
        check("after_reset_len",    32'(last_len), 32'd1);
        check("after_reset_frames", 32'(n_frames), 32'(exp_frames));
        check("after_reset_errs",   32'(n_errs),   32'(exp_errs));

        check("no_coincide", 32'(n_coincide), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
